if_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a single-outstanding request/ready handshake to instruction memory.
- Presents {instruction, address} to IF/ID each cycle, or a bubble (zero) when no instruction is available.
- Holds a fetched instruction while IF/ID is stalled; redirects on branch/jump from EX, discarding in-flight fetches.

---
 rtl/if_fetch_pkg.sv | 14 +
 rtl/if_fetch.sv | 146 ++++++++++++++
 tb/tb_if_fetch.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared encodings and constants for the RV32I instruction-fetch stage.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] BUBBLE         = 32'h0000_0000;
  localparam logic [31:0] PC_INC         = 32'd4;
  localparam int          STALL_IFID_BIT = 1;

endpackage

// File: rtl/if_fetch.sv
// IF stage: owns the PC, single-outstanding fetch, holds the word while IF/ID stalls, redirects on branch.
// Optional IF_MISALIGN_EXC_EN keeps raw branch targets in the PC and adds if_misalign_out.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_in,
  input  logic [31:0]        branch_target_in,
  output logic               mem_req_out,
  output logic [31:0]        mem_addr_out,
  input  logic               mem_ready_in,
  input  logic [31:0]        mem_rdata_in,
  output logic [31:0]        if_inst_out,
  output logic [31:0]        if_addr_out,
`ifdef IF_MISALIGN_EXC_EN
  output logic               if_misalign_out,
`endif
  output logic               if_stall_req_out
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_areg, w_areg_nxt;
  logic [31:0]  r_buf, w_buf_nxt;
  logic [31:0]  r_bufaddr, w_bufaddr_nxt;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_word;
  logic [31:0]  w_areg_word;
  logic         w_consumed;
  logic         w_valid;
  logic         w_unused_stall;

  assign w_consumed = ~stall[STALL_IFID_BIT];

`ifdef IF_MISALIGN_EXC_EN
  // PC keeps the raw target so the misalignment is visible downstream; memory only sees words.
  assign w_target       = branch_target_in;
  assign w_pc_word      = {r_pc[31:2], 2'b00};
  assign w_areg_word    = {r_areg[31:2], 2'b00};
  assign w_unused_stall = ^{stall[STALL_W-1:STALL_IFID_BIT+1], stall[STALL_IFID_BIT-1:0]};
  assign if_misalign_out = w_valid & (|if_addr_out[1:0]);
`else
  assign w_target       = {branch_target_in[31:2], 2'b00};
  assign w_pc_word      = r_pc;
  assign w_areg_word    = r_areg;
  assign w_unused_stall = ^{stall[STALL_W-1:STALL_IFID_BIT+1], stall[STALL_IFID_BIT-1:0],
                            branch_target_in[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_areg    <= BUBBLE;
      r_buf     <= BUBBLE;
      r_bufaddr <= BUBBLE;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_areg    <= w_areg_nxt;
      r_buf     <= w_buf_nxt;
      r_bufaddr <= w_bufaddr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_areg_nxt    = r_areg;
    w_buf_nxt     = r_buf;
    w_bufaddr_nxt = r_bufaddr;
    // Redirect outranks stall; any word arriving alongside it is dropped.
    case (r_state)
      ST_FETCH: begin
        if (branch_flag_in) begin
          w_pc_nxt = w_target;
          if (!mem_ready_in) begin
            w_areg_nxt  = r_pc;
            w_state_nxt = ST_DISCARD;
          end
        end else if (mem_ready_in) begin
          if (w_consumed) begin
            w_pc_nxt = r_pc + PC_INC;
          end else begin
            w_buf_nxt     = mem_rdata_in;
            w_bufaddr_nxt = r_pc;
            w_state_nxt   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (branch_flag_in) begin
          w_pc_nxt    = w_target;
          w_state_nxt = ST_FETCH;
        end else if (w_consumed) begin
          w_pc_nxt    = r_bufaddr + PC_INC;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (branch_flag_in) w_pc_nxt = w_target;
        if (mem_ready_in) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_req_out      = 1'b0;
    mem_addr_out     = w_pc_word;
    if_inst_out      = BUBBLE;
    if_addr_out      = BUBBLE;
    w_valid          = 1'b0;
    if_stall_req_out = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req_out      = 1'b1;
        if_stall_req_out = ~mem_ready_in;
        if (mem_ready_in && !branch_flag_in) begin
          w_valid     = 1'b1;
          if_inst_out = mem_rdata_in;
          if_addr_out = r_pc;
        end
      end
      ST_HOLD: begin
        if (!branch_flag_in) begin
          w_valid     = 1'b1;
          if_inst_out = r_buf;
          if_addr_out = r_bufaddr;
        end
      end
      ST_DISCARD: begin
        mem_req_out      = 1'b1;
        mem_addr_out     = w_areg_word;
        if_stall_req_out = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized scoreboard run.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_in;
  logic [31:0] branch_target_in;
  logic        mem_ready_in;
  logic        mem_req_out, if_stall_req_out;
  logic [31:0] mem_addr_out, mem_rdata_in, if_inst_out, if_addr_out;
  logic        w_req, w_sreq;
  logic [31:0] w_maddr, w_rdata, w_inst, w_iaddr;
`ifdef IF_MISALIGN_EXC_EN
  logic        misalign, w_misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory content: never zero, so a non-bubble is always distinguishable.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a ^ 32'hDEAD_0000) | 32'h3;
  endfunction

  assign mem_rdata_in = memfn(mem_addr_out);
  assign w_rdata      = memfn(w_maddr);

  if_fetch #(.RESET_PC(32'h0000_0000), .STALL_W(6)) u_dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_in(branch_flag_in), .branch_target_in(branch_target_in),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
    .mem_ready_in(mem_ready_in), .mem_rdata_in(mem_rdata_in),
    .if_inst_out(if_inst_out), .if_addr_out(if_addr_out),
`ifdef IF_MISALIGN_EXC_EN
    .if_misalign_out(misalign),
`endif
    .if_stall_req_out(if_stall_req_out)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC), .STALL_W(6)) u_wrap (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_in(branch_flag_in), .branch_target_in(branch_target_in),
    .mem_req_out(w_req), .mem_addr_out(w_maddr),
    .mem_ready_in(mem_ready_in), .mem_rdata_in(w_rdata),
    .if_inst_out(w_inst), .if_addr_out(w_iaddr),
`ifdef IF_MISALIGN_EXC_EN
    .if_misalign_out(w_misalign),
`endif
    .if_stall_req_out(w_sreq)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = '0; branch_flag_in = 1'b0; branch_target_in = '0; mem_ready_in = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (mem_req_out !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b want 1", mem_req_out); end
    n_checks++; if (mem_addr_out !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr_out); end
    n_checks++; if (if_inst_out !== 32'h0 || if_addr_out !== 32'h0) begin n_fail++; $display("FAIL reset_bubble: got %h/%h want 0/0", if_inst_out, if_addr_out); end
    n_checks++; if (if_stall_req_out !== 1'b1) begin n_fail++; $display("FAIL reset_stallreq: got %b want 1", if_stall_req_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (mem_addr_out !== 32'(4*i) || if_addr_out !== 32'(4*i) || if_inst_out !== memfn(32'(4*i)))
        begin n_fail++; $display("FAIL b2b_%0d: got addr %h/%h inst %h want %h", i, mem_addr_out, if_addr_out, if_inst_out, 4*i); end
      cyc();
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_ready_in = 1'b1;
    cyc(); cyc();
    mem_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (mem_addr_out !== 32'h8 || if_stall_req_out !== 1'b1 || if_inst_out !== 32'h0)
        begin n_fail++; $display("FAIL wait_%0d: got addr %h sreq %b inst %h want 8/1/0", i, mem_addr_out, if_stall_req_out, if_inst_out); end
      cyc();
    end
    mem_ready_in = 1'b1;
    #1;
    n_checks++; if (if_inst_out !== memfn(32'h8) || if_addr_out !== 32'h8 || if_stall_req_out !== 1'b0)
      begin n_fail++; $display("FAIL wait_deliver: got %h@%h sreq %b want %h@8", if_inst_out, if_addr_out, if_stall_req_out, memfn(32'h8)); end
    cyc();
    mem_ready_in = 1'b0;
    #1;
    n_checks++; if (mem_addr_out !== 32'hC || if_inst_out !== 32'h0)
      begin n_fail++; $display("FAIL wait_once: got addr %h inst %h want c/0", mem_addr_out, if_inst_out); end
  endtask

  task automatic test_hold();
    do_reset();
    mem_ready_in = 1'b1;
    cyc();
    stall = 6'b000010;
    #1;
    n_checks++; if (if_inst_out !== memfn(32'h4) || if_addr_out !== 32'h4)
      begin n_fail++; $display("FAIL hold_first: got %h@%h want %h@4", if_inst_out, if_addr_out, memfn(32'h4)); end
    cyc();
    #1;
    n_checks++; if (mem_req_out !== 1'b0 || if_inst_out !== memfn(32'h4) || if_addr_out !== 32'h4)
      begin n_fail++; $display("FAIL hold_keep: got req %b %h@%h want 0 %h@4", mem_req_out, if_inst_out, if_addr_out, memfn(32'h4)); end
    stall = '0;
    #1;
    n_checks++; if (if_inst_out !== memfn(32'h4) || if_addr_out !== 32'h4)
      begin n_fail++; $display("FAIL hold_release: got %h@%h want %h@4", if_inst_out, if_addr_out, memfn(32'h4)); end
    cyc();
    mem_ready_in = 1'b0;
    #1;
    n_checks++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h8)
      begin n_fail++; $display("FAIL hold_next: got req %b addr %h want 1/8", mem_req_out, mem_addr_out); end
  endtask

  task automatic test_branch_discard();
    do_reset();
    mem_ready_in = 1'b1;
    cyc(); cyc();
    mem_ready_in = 1'b0; branch_flag_in = 1'b1; branch_target_in = 32'h100;
    #1;
    n_checks++; if (if_inst_out !== 32'h0 || if_addr_out !== 32'h0)
      begin n_fail++; $display("FAIL br_bubble: got %h@%h want 0@0", if_inst_out, if_addr_out); end
    cyc();
    branch_flag_in = 1'b0;
    #1;
    n_checks++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h8 || if_stall_req_out !== 1'b1)
      begin n_fail++; $display("FAIL br_discard: got req %b addr %h sreq %b want 1/8/1", mem_req_out, mem_addr_out, if_stall_req_out); end
    cyc();
    mem_ready_in = 1'b1;
    #1;
    n_checks++; if (if_inst_out !== 32'h0 || if_stall_req_out !== 1'b1)
      begin n_fail++; $display("FAIL br_drop: got inst %h sreq %b want 0/1", if_inst_out, if_stall_req_out); end
    cyc();
    mem_ready_in = 1'b0;
    #1;
    n_checks++; if (mem_addr_out !== 32'h100 || if_inst_out !== 32'h0)
      begin n_fail++; $display("FAIL br_target: got addr %h inst %h want 100/0", mem_addr_out, if_inst_out); end
    mem_ready_in = 1'b1;
    #1;
    n_checks++; if (if_inst_out !== memfn(32'h100) || if_addr_out !== 32'h100)
      begin n_fail++; $display("FAIL br_deliver: got %h@%h want %h@100", if_inst_out, if_addr_out, memfn(32'h100)); end
    cyc();
  endtask

  task automatic test_branch_hold();
    logic [31:0] exp_iaddr;
`ifdef IF_MISALIGN_EXC_EN
    exp_iaddr = 32'h203;
`else
    exp_iaddr = 32'h200;
`endif
    do_reset();
    mem_ready_in = 1'b1; stall = 6'b000010;
    cyc();
    branch_flag_in = 1'b1; branch_target_in = 32'h203;
    #1;
    n_checks++; if (if_inst_out !== 32'h0 || if_addr_out !== 32'h0 || mem_req_out !== 1'b0)
      begin n_fail++; $display("FAIL brh_bubble: got %h@%h req %b want 0@0 req 0", if_inst_out, if_addr_out, mem_req_out); end
    cyc();
    branch_flag_in = 1'b0; stall = '0; mem_ready_in = 1'b0;
    #1;
    n_checks++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h200)
      begin n_fail++; $display("FAIL brh_target: got req %b addr %h want 1/200", mem_req_out, mem_addr_out); end
    mem_ready_in = 1'b1;
    #1;
    n_checks++; if (if_addr_out !== exp_iaddr || if_inst_out !== memfn(32'h200))
      begin n_fail++; $display("FAIL brh_deliver: got %h@%h want %h@%h", if_inst_out, if_addr_out, memfn(32'h200), exp_iaddr); end
    cyc();
  endtask

  task automatic test_wrap();
    do_reset();
    mem_ready_in = 1'b1;
    #1;
    n_checks++; if (w_maddr !== 32'hFFFF_FFFC || w_iaddr !== 32'hFFFF_FFFC)
      begin n_fail++; $display("FAIL wrap_first: got %h/%h want fffffffc", w_maddr, w_iaddr); end
    cyc();
    #1;
    n_checks++; if (w_maddr !== 32'h0 || w_inst !== memfn(32'h0))
      begin n_fail++; $display("FAIL wrap_second: got addr %h inst %h want 0/%h", w_maddr, w_inst, memfn(32'h0)); end
  endtask

  task automatic test_rst_discard();
    do_reset();
    branch_flag_in = 1'b1; branch_target_in = 32'h300;
    cyc();
    branch_flag_in = 1'b0;
    #1;
    n_checks++; if (if_stall_req_out !== 1'b1 || mem_addr_out !== 32'h0)
      begin n_fail++; $display("FAIL rstd_in_discard: got sreq %b addr %h want 1/0", if_stall_req_out, mem_addr_out); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    n_checks++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h0 || w_maddr !== 32'hFFFF_FFFC)
      begin n_fail++; $display("FAIL rstd_after: got req %b addr %h wrap %h want 1/0/fffffffc", mem_req_out, mem_addr_out, w_maddr); end
  endtask

  // Scoreboard: delivered words must form the architectural stream (sequential, redirected by branches).
  task automatic test_random();
    logic [31:0] exp_next, prev_addr, prev_inst, prev_iaddr;
    logic        prev_pending, prev_held;
    int          idle, max_idle;
    do_reset();
    exp_next = 32'h0; prev_pending = 1'b0; prev_held = 1'b0; idle = 0; max_idle = 0;
    prev_addr = '0; prev_inst = '0; prev_iaddr = '0;
    for (int c = 0; c < 1500; c++) begin
      mem_ready_in     = ($urandom_range(0, 3) != 0);
      stall            = ($urandom_range(0, 3) == 0) ? 6'b000010 : 6'($urandom_range(0, 1) ? 6'b101101 : 6'b0);
      branch_flag_in   = ($urandom_range(0, 11) == 0);
      branch_target_in = $urandom & 32'h0000_FFFF;
      #1;
      if (prev_pending) begin
        n_checks++; if (mem_req_out !== 1'b1 || mem_addr_out !== prev_addr)
          begin n_fail++; $display("FAIL rnd_req_stable c%0d: got %b/%h want 1/%h", c, mem_req_out, mem_addr_out, prev_addr); end
      end
      if (branch_flag_in) begin
        n_checks++; if (if_inst_out !== 32'h0 || if_addr_out !== 32'h0)
          begin n_fail++; $display("FAIL rnd_branch_bubble c%0d: got %h@%h want 0@0", c, if_inst_out, if_addr_out); end
      end else if (prev_held) begin
        n_checks++; if (if_inst_out !== prev_inst || if_addr_out !== prev_iaddr || mem_req_out !== 1'b0)
          begin n_fail++; $display("FAIL rnd_hold c%0d: got %h@%h req %b want %h@%h req 0", c, if_inst_out, if_addr_out, mem_req_out, prev_inst, prev_iaddr); end
      end
      if (if_stall_req_out === 1'b1) begin
        n_checks++; if (if_inst_out !== 32'h0 || mem_req_out !== 1'b1)
          begin n_fail++; $display("FAIL rnd_stallreq c%0d: got inst %h req %b want 0/1", c, if_inst_out, mem_req_out); end
      end
      if (if_inst_out !== 32'h0) begin
        idle = 0;
        n_checks++; if (if_addr_out !== exp_next || if_inst_out !== memfn({if_addr_out[31:2], 2'b00}))
          begin n_fail++; $display("FAIL rnd_stream c%0d: got %h@%h want %h@%h", c, if_inst_out, if_addr_out, memfn(exp_next), exp_next); end
        if (!stall[STALL_IFID_BIT]) exp_next = exp_next + 32'd4;
      end else begin
        idle++;
        if (idle > max_idle) max_idle = idle;
      end
`ifdef IF_MISALIGN_EXC_EN
      if (branch_flag_in) exp_next = branch_target_in;
`else
      if (branch_flag_in) exp_next = {branch_target_in[31:2], 2'b00};
`endif
      prev_pending = mem_req_out && !mem_ready_in;
      prev_addr    = mem_addr_out;
      prev_held    = (if_inst_out !== 32'h0) && stall[STALL_IFID_BIT];
      prev_inst    = if_inst_out;
      prev_iaddr   = if_addr_out;
      cyc();
    end
    n_checks++; if (max_idle > 40)
      begin n_fail++; $display("FAIL rnd_progress: got %0d idle cycles want <= 40", max_idle); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mem_wait();
    test_hold();
    test_branch_discard();
    test_branch_hold();
    test_wrap();
    test_rst_discard();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
